// File: rtl/mtimer_bank_pkg.sv
// Shared types and register map for the machine timer bank.
// Decoding lives here so the top and any checker agree on the map.
package mtimer_bank_pkg;

   typedef enum logic [1:0] {
      UNIT_BYTE = 2'd0,
      UNIT_HALF = 2'd1,
      UNIT_WORD = 2'd2
   } mem_unit_t;

   localparam logic [15:0] OFF_MSIP     = 16'h0000;
   localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
   localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
   localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;
   localparam logic [15:0] OFF_PRESCALE = 16'hC000;
   localparam logic [15:0] OFF_CTRL     = 16'hC004;

   localparam int MAX_HARTS = 8;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_MSIP,
      REG_CMP_LO,
      REG_CMP_HI,
      REG_MTIME_LO,
      REG_MTIME_HI,
      REG_PRESCALE,
      REG_CTRL
   } reg_kind_t;

   typedef struct packed {
      reg_kind_t  kind;
      logic [2:0] idx;
   } reg_dec_t;

   // Hart range is not checked here; the top knows HARTS.
   function automatic reg_dec_t decode_addr(input logic [15:0] addr);
      reg_dec_t d;
      d.kind = REG_NONE;
      d.idx  = addr[4:2];
      if (addr[15:5] == OFF_MSIP[15:5]) begin
         d.kind = REG_MSIP;
         d.idx  = addr[4:2];
      end else if (addr[15:6] == OFF_MTIMECMP[15:6]) begin
         d.kind = addr[2] ? REG_CMP_HI : REG_CMP_LO;
         d.idx  = addr[5:3];
      end else if (addr == OFF_MTIME_LO) begin
         d.kind = REG_MTIME_LO;
      end else if (addr == OFF_MTIME_HI) begin
         d.kind = REG_MTIME_HI;
      end else if (addr == OFF_PRESCALE) begin
         d.kind = REG_PRESCALE;
      end else if (addr == OFF_CTRL) begin
         d.kind = REG_CTRL;
      end
      return d;
   endfunction

endpackage

// File: rtl/mtimer_bank_if.sv
// Register bus between the system decoder (master) and the timer bank (slave).
// Protocol: a request is any cycle with sel & (mem_re | mem_we); there is no
// backpressure, and the response (rd_valid/mem_rd or an error pulse) comes
// exactly one cycle later. mem_we has priority over mem_re.
interface mtimer_bank_if;
   import mtimer_bank_pkg::*;

   logic        sel;
   logic        mem_re;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wd;
   mem_unit_t   mem_wd_unit;
   mem_unit_t   mem_rd_unit;
   logic [31:0] mem_rd;
   logic        rd_valid;
   logic        access_fault;
   logic        addr_misaligned;

   modport master (
      output sel, mem_re, mem_we, mem_addr, mem_wd, mem_wd_unit, mem_rd_unit,
      input  mem_rd, rd_valid, access_fault, addr_misaligned
   );

   modport slave (
      input  sel, mem_re, mem_we, mem_addr, mem_wd, mem_wd_unit, mem_rd_unit,
      output mem_rd, rd_valid, access_fault, addr_misaligned
   );

endinterface

// File: rtl/mtimer_bank_cmp.sv
// One hart's mtimecmp register and registered timer-interrupt flag.
// mtip compares next-state values so it lines up with the mtime register.
module mtimer_cmp (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic        hi,
   input  logic [31:0] wd,
   input  logic [63:0] mtime_nxt,
   output logic [63:0] mtimecmp,
   output logic        mtip
);

   logic [63:0] cmp_q, cmp_d;
   logic        mtip_q, mtip_d;

   always_comb begin
      cmp_d = cmp_q;
      if (we) begin
         if (hi) cmp_d[63:32] = wd;
         else    cmp_d[31:0]  = wd;
      end
      mtip_d = (mtime_nxt >= cmp_d);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cmp_q  <= '1;
         mtip_q <= 1'b0;
      end else begin
         cmp_q  <= cmp_d;
         mtip_q <= mtip_d;
      end
   end

   assign mtimecmp = cmp_q;
   assign mtip     = mtip_q;

endmodule

// File: rtl/mtimer_bank.sv
// Machine timer bank: shared prescaled 64-bit mtime, per-hart mtimecmp/msip,
// and a one-cycle-latency register interface with error pulses.
module mtimer_bank
   import mtimer_bank_pkg::*;
#(
   parameter int HARTS      = 2,
   parameter int PRESCALE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   mtimer_bank_if.slave      bus,
   input  logic              halt,
   output logic [63:0]       mtime,
   output logic [HARTS-1:0]  mtip,
   output logic [HARTS-1:0]  msip
);

   logic [63:0]           mtime_q, mtime_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic                  enable_q, enable_d;
   logic [HARTS-1:0]      msip_q, msip_d;
   logic [31:0]           mem_rd_q, mem_rd_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  access_fault_q, access_fault_d;
   logic                  addr_misaligned_q, addr_misaligned_d;

   logic       is_wr, is_rd, is_req, aligned, hart_ok, hit, wr_ok;
   logic       run, tick;
   mem_unit_t  unit;
   reg_dec_t   dec;
   logic [31:0] rd_data;

   logic [HARTS-1:0] cmp_we;
   logic             cmp_hi;
   logic [63:0]      cmp_val [HARTS];

   // Request decode; the write unit governs alignment when both strobes are set.
   always_comb begin
      is_wr   = bus.sel & bus.mem_we;
      is_rd   = bus.sel & bus.mem_re & ~bus.mem_we;
      is_req  = is_wr | is_rd;
      unit    = bus.mem_we ? bus.mem_wd_unit : bus.mem_rd_unit;
      aligned = (unit == UNIT_WORD) && (bus.mem_addr[1:0] == 2'b00);
      dec     = decode_addr(bus.mem_addr);
      hart_ok = (int'(dec.idx) < HARTS);
      case (dec.kind)
         REG_MSIP, REG_CMP_LO, REG_CMP_HI: hit = hart_ok;
         REG_NONE:                         hit = 1'b0;
         default:                          hit = 1'b1;
      endcase
      wr_ok = is_wr & aligned & hit;
   end

   // Timebase and register writes; a write to an mtime half beats the tick.
   always_comb begin
      run        = enable_q & ~halt;
      tick       = run & (pcnt_q == prescale_q);
      pcnt_d     = pcnt_q;
      if (run) pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      prescale_d = prescale_q;
      enable_d   = enable_q;
      msip_d     = msip_q;
      if (wr_ok) begin
         case (dec.kind)
            REG_MSIP: begin
               for (int h = 0; h < HARTS; h++)
                  if (dec.idx == 3'(h)) msip_d[h] = bus.mem_wd[0];
            end
            REG_MTIME_LO: mtime_d = {mtime_q[63:32], bus.mem_wd};
            REG_MTIME_HI: mtime_d = {bus.mem_wd, mtime_q[31:0]};
            REG_PRESCALE: begin
               prescale_d = bus.mem_wd[PRESCALE_W-1:0];
               pcnt_d     = '0;
            end
            REG_CTRL: enable_d = bus.mem_wd[0];
            default: ;
         endcase
      end
   end

   always_comb begin
      cmp_hi = (dec.kind == REG_CMP_HI);
      cmp_we = '0;
      for (int h = 0; h < HARTS; h++)
         cmp_we[h] = wr_ok & ((dec.kind == REG_CMP_LO) | (dec.kind == REG_CMP_HI))
                     & (dec.idx == 3'(h));
   end

   always_comb begin
      rd_data = '0;
      case (dec.kind)
         REG_MSIP: begin
            for (int h = 0; h < HARTS; h++)
               if (dec.idx == 3'(h)) rd_data = {31'b0, msip_q[h]};
         end
         REG_CMP_LO: begin
            for (int h = 0; h < HARTS; h++)
               if (dec.idx == 3'(h)) rd_data = cmp_val[h][31:0];
         end
         REG_CMP_HI: begin
            for (int h = 0; h < HARTS; h++)
               if (dec.idx == 3'(h)) rd_data = cmp_val[h][63:32];
         end
         REG_MTIME_LO: rd_data = mtime_q[31:0];
         REG_MTIME_HI: rd_data = mtime_q[63:32];
         REG_PRESCALE: rd_data = 32'(prescale_q);
         REG_CTRL:     rd_data = {31'b0, enable_q};
         default:      rd_data = '0;
      endcase
   end

   // Erroneous reads still complete, returning zero.
   always_comb begin
      rd_valid_d        = is_rd;
      mem_rd_d          = mem_rd_q;
      if (is_rd) mem_rd_d = (aligned & hit) ? rd_data : '0;
      access_fault_d    = is_req & aligned & ~hit;
      addr_misaligned_d = is_req & ~aligned;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mtime_q           <= '0;
         pcnt_q            <= '0;
         prescale_q        <= '0;
         enable_q          <= 1'b1;
         msip_q            <= '0;
         mem_rd_q          <= '0;
         rd_valid_q        <= 1'b0;
         access_fault_q    <= 1'b0;
         addr_misaligned_q <= 1'b0;
      end else begin
         mtime_q           <= mtime_d;
         pcnt_q            <= pcnt_d;
         prescale_q        <= prescale_d;
         enable_q          <= enable_d;
         msip_q            <= msip_d;
         mem_rd_q          <= mem_rd_d;
         rd_valid_q        <= rd_valid_d;
         access_fault_q    <= access_fault_d;
         addr_misaligned_q <= addr_misaligned_d;
      end
   end

   for (genvar g = 0; g < HARTS; g++) begin : g_cmp
      mtimer_cmp u_cmp (
         .clk       (clk),
         .reset     (reset),
         .we        (cmp_we[g]),
         .hi        (cmp_hi),
         .wd        (bus.mem_wd),
         .mtime_nxt (mtime_d),
         .mtimecmp  (cmp_val[g]),
         .mtip      (mtip[g])
      );
   end

   assign mtime               = mtime_q;
   assign msip                = msip_q;
   assign bus.mem_rd          = mem_rd_q;
   assign bus.rd_valid        = rd_valid_q;
   assign bus.access_fault    = access_fault_q;
   assign bus.addr_misaligned = addr_misaligned_q;

endmodule

// File: tb/tb_mtimer_bank.sv
// Directed bench for mtimer_bank with four harts; expected values are hand-computed.
module tb_mtimer_bank;
   import mtimer_bank_pkg::*;

   localparam int HARTS = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             halt = 1'b0;
   logic [63:0]      mtime;
   logic [HARTS-1:0] mtip, msip;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   mtimer_bank_if bus_if();

   mtimer_bank #(.HARTS(HARTS), .PRESCALE_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave),
      .halt  (halt),
      .mtime (mtime),
      .mtip  (mtip),
      .msip  (msip)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus_if.sel         = 1'b0;
      bus_if.mem_re      = 1'b0;
      bus_if.mem_we      = 1'b0;
      bus_if.mem_addr    = '0;
      bus_if.mem_wd      = '0;
      bus_if.mem_wd_unit = UNIT_WORD;
      bus_if.mem_rd_unit = UNIT_WORD;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [31:0] d,
                            input mem_unit_t u = UNIT_WORD);
      bus_if.sel         = 1'b1;
      bus_if.mem_we      = 1'b1;
      bus_if.mem_re      = 1'b0;
      bus_if.mem_addr    = a;
      bus_if.mem_wd      = d;
      bus_if.mem_wd_unit = u;
      idle(1);
      bus_idle();
   endtask

   task automatic bus_read(input logic [15:0] a, input mem_unit_t u = UNIT_WORD);
      bus_if.sel         = 1'b1;
      bus_if.mem_re      = 1'b1;
      bus_if.mem_we      = 1'b0;
      bus_if.mem_addr    = a;
      bus_if.mem_rd_unit = u;
      idle(1);
      bus_idle();
   endtask

   // Issue a read and compare both rd_valid and the returned data.
   task automatic read_check(input string tag, input logic [15:0] a, input mem_unit_t u,
                             input logic [31:0] exp);
      exp_q.push_back(exp);
      bus_read(a, u);
      check({tag, "_valid"}, 64'(bus_if.rd_valid), 64'd1);
      check({tag, "_data"}, 64'(bus_if.mem_rd), 64'(exp_q.pop_front()));
   endtask

   initial begin
      bus_idle();
      idle(3);
      check("rst_mtime", mtime, 64'd0);
      check("rst_mtip", 64'(mtip), 64'd0);
      check("rst_msip", 64'(msip), 64'd0);
      check("rst_rd_valid", 64'(bus_if.rd_valid), 64'd0);
      check("rst_mem_rd", 64'(bus_if.mem_rd), 64'd0);
      check("rst_fault", 64'(bus_if.access_fault), 64'd0);
      check("rst_misalign", 64'(bus_if.addr_misaligned), 64'd0);
      bus_read(OFF_CTRL);
      check("rst_no_resp", 64'(bus_if.rd_valid), 64'd0);

      // Default prescale 0, enabled: one increment per edge.
      reset = 1'b1;
      idle(10);
      check("count_10", mtime, 64'd10);
      check("count_mtip", 64'(mtip), 64'd0);

      bus_write(OFF_CTRL, 32'd0);
      idle(3);
      check("freeze_en0", mtime, 64'd11);

      // Prescale 3: one tick every four edges once enabled.
      bus_write(OFF_MTIME_LO, 32'd0);
      bus_write(OFF_MTIME_HI, 32'd0);
      bus_write(OFF_PRESCALE, 32'd3);
      bus_write(OFF_CTRL, 32'd1);
      idle(3);
      check("ps3_no_tick", mtime, 64'd0);
      idle(1);
      check("ps3_tick1", mtime, 64'd1);
      idle(4);
      check("ps3_tick2", mtime, 64'd2);
      halt = 1'b1;
      idle(8);
      check("halt_freeze", mtime, 64'd2);
      halt = 1'b0;
      idle(4);
      check("halt_resume", mtime, 64'd3);

      // Carry into the high half, then writes coincident with ticks.
      bus_write(OFF_CTRL, 32'd0);
      bus_write(OFF_PRESCALE, 32'd0);
      bus_write(OFF_MTIME_HI, 32'd0);
      bus_write(OFF_MTIME_LO, 32'hFFFF_FFFF);
      check("lo_set", mtime, 64'h0000_0000_FFFF_FFFF);
      bus_write(OFF_CTRL, 32'd1);
      idle(1);
      check("carry", mtime, 64'h0000_0001_0000_0000);
      bus_write(OFF_MTIME_LO, 32'h1234_5678);
      check("lo_wr_tick", mtime, 64'h0000_0001_1234_5678);
      bus_write(OFF_MTIME_HI, 32'h0000_000A);
      check("hi_wr_tick", mtime, 64'h0000_000A_1234_5678);

      bus_write(OFF_CTRL, 32'd0);
      bus_write(OFF_MTIME_HI, 32'hFFFF_FFFF);
      bus_write(OFF_MTIME_LO, 32'hFFFF_FFFF);
      bus_write(OFF_CTRL, 32'd1);
      idle(1);
      check("wrap", mtime, 64'd0);

      // mtimecmp[1] = 0x20 with mtime approaching from 0x1E.
      bus_write(OFF_CTRL, 32'd0);
      bus_write(OFF_MTIME_LO, 32'h1E);
      bus_write(OFF_MTIME_HI, 32'd0);
      bus_write(16'h4008, 32'h20);
      bus_write(16'h400C, 32'h0);
      check("mtip_below", 64'(mtip), 64'd0);
      bus_write(OFF_CTRL, 32'd1);
      idle(1);
      check("mtip_1f_time", mtime, 64'h1F);
      check("mtip_1f", 64'(mtip), 64'd0);
      idle(1);
      check("mtip_rise_time", mtime, 64'h20);
      check("mtip_rise", 64'(mtip), 64'b0010);
      bus_write(16'h4008, 32'h100);
      check("mtip_fall", 64'(mtip), 64'd0);
      bus_write(OFF_CTRL, 32'd0);
      read_check("cmp1_lo", 16'h4008, UNIT_WORD, 32'h100);
      read_check("cmp1_hi", 16'h400C, UNIT_WORD, 32'h0);
      read_check("cmp0_hi", 16'h4004, UNIT_WORD, 32'hFFFF_FFFF);

      // Error paths.
      bus_write(16'h0000, 32'd1, UNIT_BYTE);
      check("byte_wr_mis", 64'(bus_if.addr_misaligned), 64'd1);
      check("byte_wr_fault", 64'(bus_if.access_fault), 64'd0);
      check("byte_wr_msip", 64'(msip), 64'd0);
      idle(1);
      check("mis_pulse_end", 64'(bus_if.addr_misaligned), 64'd0);
      read_check("pre_fault", 16'h4004, UNIT_WORD, 32'hFFFF_FFFF);
      read_check("unmapped", 16'h8000, UNIT_WORD, 32'h0);
      check("unmapped_fault", 64'(bus_if.access_fault), 64'd1);
      read_check("pre_mis", 16'h4008, UNIT_WORD, 32'h100);
      read_check("half_rd", 16'h4008, UNIT_HALF, 32'h0);
      check("half_rd_mis", 64'(bus_if.addr_misaligned), 64'd1);
      read_check("off_rd", 16'hC002, UNIT_WORD, 32'h0);
      check("off_rd_mis", 64'(bus_if.addr_misaligned), 64'd1);

      // msip and hart range.
      bus_write(16'h000C, 32'd1);
      check("msip3_set", 64'(msip), 64'b1000);
      read_check("msip3_rd", 16'h000C, UNIT_WORD, 32'd1);
      idle(1);
      check("rd_valid_drop", 64'(bus_if.rd_valid), 64'd0);
      check("rd_hold", 64'(bus_if.mem_rd), 64'd1);
      bus_write(16'h0010, 32'd1);
      check("hart4_fault", 64'(bus_if.access_fault), 64'd1);
      check("hart4_msip", 64'(msip), 64'b1000);
      bus_write(16'h4020, 32'd0);
      check("cmp4_fault", 64'(bus_if.access_fault), 64'd1);

      bus_if.sel      = 1'b1;
      bus_if.mem_re   = 1'b1;
      bus_if.mem_we   = 1'b1;
      bus_if.mem_addr = 16'h0000;
      bus_if.mem_wd   = 32'd1;
      idle(1);
      bus_idle();
      check("rw_both_msip", 64'(msip), 64'b1001);
      check("rw_both_valid", 64'(bus_if.rd_valid), 64'd0);

      bus_write(16'h0008, 32'hFFFF_FFFE);
      check("msip_unused_bits", 64'(msip), 64'b1001);
      bus_write(OFF_PRESCALE, 32'hFFFF_FFFF);
      read_check("prescale_rd", OFF_PRESCALE, UNIT_WORD, 32'h0000_00FF);
      bus_write(OFF_CTRL, 32'hFFFF_FFFF);
      read_check("ctrl_rd", OFF_CTRL, UNIT_WORD, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mtimer_bank.md
MTIMER_BANK -- requirements
Module: mtimer_bank

Interface
REQ-001 Parameter HARTS, default 2, number of harts served (1..8).
REQ-002 Parameter PRESCALE_W, default 8, prescaler width in bits.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-low reset: sampled on clk, asserted when 0.
REQ-005 Port sel  in  1  block selected by the system address decoder.
REQ-006 Port mem_re, mem_we  in  1 each  read and write strobes.
REQ-007 Port mem_addr  in  16  byte offset within the block.
REQ-008 Port mem_wd  in  32  write data.
REQ-009 Port mem_wd_unit, mem_rd_unit  in  2 each  access size (mem_unit_t).
REQ-010 Port mem_rd  out  32  registered read data.
REQ-011 Port rd_valid  out  1  mem_rd is valid this cycle.
REQ-012 Port access_fault, addr_misaligned  out  1 each  one-cycle error pulses.
REQ-013 Port halt  in  1  debug halt: freezes mtime.
REQ-014 Port mtime  out  64  current time value.
REQ-015 Port mtip, msip  out  HARTS each  per-hart timer and software interrupt pending.

Function
REQ-016 Register map: msip[h] 0x0000+4h (bit 0 only); mtimecmp[h] lo 0x4000+8h, hi 0x4004+8h; mtime lo 0xBFF8, hi 0xBFFC; prescale 0xC000 (low PRESCALE_W bits); ctrl 0xC004 (bit 0 enable).
REQ-017 Only WORD accesses at addr[1:0]=0 are legal; any other access while sel pulses addr_misaligned next cycle, no state change, rd_valid=1 with mem_rd=0 for reads.
REQ-018 Legal access to an unmapped offset, or to an hart index >= HARTS, pulses access_fault next cycle, writes ignored, reads return 0 with rd_valid=1.
REQ-019 Read latency exactly 1 cycle: request at cycle N -> mem_rd/rd_valid at N+1; rd_valid is 0 otherwise; mem_rd holds its last value when rd_valid=0.
REQ-020 mem_re and mem_we asserted together: write performed, read ignored, no rd_valid.
REQ-021 Unused register bits read as 0; writes to them are discarded.
REQ-022 Prescaler counter pcnt counts 0..prescale; tick asserts when pcnt==prescale and wraps pcnt to 0; prescale=0 gives a tick every cycle.
REQ-023 On tick with enable=1 and halt=0, mtime increments by 1 with full 64-bit carry; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-024 enable=0 or halt=1 freezes both pcnt and mtime.
REQ-025 Writing prescale resets pcnt to 0 in the same edge.
REQ-026 Write to mtime lo or hi in the same cycle as a tick: the written half takes mem_wd, the other half keeps its old value (no carry applied); write wins over increment.
REQ-027 mtip[h] is registered: mtip[h] at N+1 = (mtime at N+1 >= mtimecmp[h] at N+1), unsigned 64-bit compare, recomputed every cycle from next-state values.
REQ-028 msip[h] equals stored msip bit; updates visible the cycle after the write.

Reset
REQ-029 While reset=0 at an edge: mtime=0, pcnt=0, prescale=0, enable=1, every mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, mtip=0, mem_rd=0, rd_valid=0, access_fault=0, addr_misaligned=0.
REQ-030 Reset overrides any concurrent access; a request in the reset cycle produces no response.

Structure
REQ-031 mem_unit_t and the register offset constants live in the shared enums package.
REQ-032 Per-hart compare logic is one sub-module, mtimer_cmp (holds mtimecmp, produces mtip), instantiated HARTS times.

Verification
REQ-033 Reset, prescale=0: after 10 enabled cycles mtime=10; mtip=0 for all harts.
REQ-034 Write prescale=3 -> mtime increments once every 4 cycles; halt=1 for 8 cycles -> mtime unchanged.
REQ-035 mtime=0xFFFF_FFFF written, hi=0, tick -> mtime=0x1_0000_0000; lo write coincident with tick -> lo=written value, hi unchanged.
REQ-036 mtimecmp[1]=0x20, mtime counts from 0x1E -> mtip[1] rises when mtime=0x20, mtip[0] stays 0; rewrite mtimecmp[1]=0x100 -> mtip[1] falls next cycle.
REQ-037 Byte write to 0x0000 -> addr_misaligned pulse, msip unchanged; word read of 0x8000 -> access_fault, rd_valid=1, mem_rd=0.
REQ-038 HARTS=4: write msip[3]=1 -> msip=4'b1000 next cycle; read 0x000C returns 1 one cycle after request.
